// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_sequencer
// Description : Sequences single-word writes and 1..16 word read bursts onto
//               a synchronous, active-low-enabled memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sequencer #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req,
    input  logic                 Wr,
    input  logic [AddrWidth-1:0] Req_Addr,
    input  logic [DataWidth-1:0] Req_Data,
    input  logic [3:0]           Burst_Len,
    output logic                 Ready,
    output logic [DataWidth-1:0] Rd_Data,
    output logic                 Rd_Valid,
    output logic                 Rd_Last,
    output logic                 Wr_Done,
    output logic [AddrWidth-1:0] Mem_Addr,
    output logic [DataWidth-1:0] Mem_DIn,
    input  logic [DataWidth-1:0] Mem_DOut,
    output logic                 Mem_Write_EN,
    output logic                 Mem_En
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_remaining;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= c_IDLE;
            r_remaining  <= 4'd0;
            Ready        <= 1'b1;
            Mem_En       <= 1'b1;
            Mem_Write_EN <= 1'b1;
            Rd_Valid     <= 1'b0;
            Rd_Last      <= 1'b0;
            Wr_Done      <= 1'b0;
            Mem_Addr     <= '0;
            Mem_DIn      <= '0;
            Rd_Data      <= '0;
        end else begin
            // Status strobes are pulses: cleared unless re-asserted below.
            Rd_Valid <= 1'b0;
            Rd_Last  <= 1'b0;
            Wr_Done  <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (Req && Ready) begin
                        Mem_Addr <= Req_Addr;
                        Mem_En   <= 1'b0;
                        Ready    <= 1'b0;
                        if (Wr) begin
                            Mem_DIn      <= Req_Data;
                            Mem_Write_EN <= 1'b0;
                            r_state      <= c_WRITE;
                        end else begin
                            Mem_Write_EN <= 1'b1;
                            r_remaining  <= Burst_Len;
                            r_state      <= c_READ;
                        end
                    end
                end

                c_READ: begin
                    // Memory presented the word for Mem_Addr on the last falling edge.
                    Rd_Data  <= Mem_DOut;
                    Rd_Valid <= 1'b1;
                    if (r_remaining != 4'd0) begin
                        Mem_Addr    <= Mem_Addr + 1'b1;
                        r_remaining <= r_remaining - 4'd1;
                    end else begin
                        Rd_Last <= 1'b1;
                        Mem_En  <= 1'b1;
                        Ready   <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end

                c_WRITE: begin
                    Mem_En       <= 1'b1;
                    Mem_Write_EN <= 1'b1;
                    Wr_Done      <= 1'b1;
                    Ready        <= 1'b1;
                    r_state      <= c_IDLE;
                end

                default: begin
                    Mem_En       <= 1'b1;
                    Mem_Write_EN <= 1'b1;
                    Ready        <= 1'b1;
                    r_state      <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sequencer
// Description : Scoreboard bench for mem_sequencer with a falling-edge memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        Wr = 1'b0;
    logic [7:0]  Req_Addr = '0;
    logic [15:0] Req_Data = '0;
    logic [3:0]  Burst_Len = '0;
    logic        Ready;
    logic [15:0] Rd_Data;
    logic        Rd_Valid;
    logic        Rd_Last;
    logic        Wr_Done;
    logic [7:0]  Mem_Addr;
    logic [15:0] Mem_DIn;
    logic [15:0] Mem_DOut = '0;
    logic        Mem_Write_EN;
    logic        Mem_En;

    mem_sequencer #(.AddrWidth(8), .DataWidth(16)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr),
        .Req_Addr(Req_Addr), .Req_Data(Req_Data), .Burst_Len(Burst_Len),
        .Ready(Ready), .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rd_Last(Rd_Last),
        .Wr_Done(Wr_Done), .Mem_Addr(Mem_Addr), .Mem_DIn(Mem_DIn),
        .Mem_DOut(Mem_DOut), .Mem_Write_EN(Mem_Write_EN), .Mem_En(Mem_En)
    );

    always #5 Clk = ~Clk;

    // Memory model: preloaded with A000+a, acts on the falling edge.
    logic [15:0] mem [256];
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'hA000 + 16'(a);
    end
    always @(negedge Clk) begin
        if (!Mem_En) begin
            if (!Mem_Write_EN) mem[Mem_Addr] <= Mem_DIn;
            else               Mem_DOut      <= mem[Mem_Addr];
        end
    end

    typedef struct {
        bit          is_wr;
        logic [15:0] data;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push_rd(input logic [15:0] d, input bit l);
        exp_t e;
        e.is_wr = 1'b0; e.data = d; e.last = l;
        sb.push_back(e);
    endtask

    task automatic push_wr();
        exp_t e;
        e.is_wr = 1'b1; e.data = '0; e.last = 1'b0;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Leaves the caller on a falling edge with Ready high.
    task automatic wait_idle();
        int n = 0;
        while (Ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (Ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: Ready=%b after %0d cycles, expected 1", Ready, n);
        end
    endtask

    task automatic start_req(input bit w, input logic [7:0] a, input logic [15:0] d,
                             input logic [3:0] len);
        wait_idle();
        Req = 1'b1; Wr = w; Req_Addr = a; Req_Data = d; Burst_Len = len;
    endtask

    // Monitor: pops an expectation for every response pulse, plus protocol checks.
    bit prev_we_low = 1'b0;
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Rd_Valid === 1'b1 || Wr_Done === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: Rd_Valid=%b Wr_Done=%b Rd_Data=%h, no response expected",
                         Rd_Valid, Wr_Done, Rd_Data);
            end else begin
                e = sb.pop_front();
                if (Wr_Done !== e.is_wr || Rd_Valid !== !e.is_wr ||
                    (!e.is_wr && (Rd_Data !== e.data || Rd_Last !== e.last))) begin
                    n_err++;
                    $display("FAIL sb_response: got wr=%b rd=%b data=%h last=%b, expected wr=%b data=%h last=%b",
                             Wr_Done, Rd_Valid, Rd_Data, Rd_Last, e.is_wr, e.data, e.last);
                end
            end
        end
        if (Rd_Last === 1'b1 && Rd_Valid !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL last_without_valid: Rd_Last=1 Rd_Valid=%b, expected 1", Rd_Valid);
        end
        if (Mem_Write_EN === 1'b0) begin
            n_vec++;
            if (Mem_En !== 1'b0 || prev_we_low) begin
                n_err++;
                $display("FAIL we_protocol: Mem_En=%b prev_we_low=%b, expected 0 and 0", Mem_En, prev_we_low);
            end
        end
        prev_we_low = (Mem_Write_EN === 1'b0);
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("rst_ready", Ready, 1);
        check("rst_mem_en", Mem_En, 1);
        check("rst_mem_we", Mem_Write_EN, 1);
        check("rst_pulses", {Rd_Valid, Rd_Last, Wr_Done}, 0);
        check("rst_addr", Mem_Addr, 0);
        check("rst_din", Mem_DIn, 0);
        check("rst_rd_data", Rd_Data, 0);

        // Single read of 0x10, with latency checks
        @(negedge Clk);
        start_req(1'b0, 8'h10, 16'h0, 4'd0);
        push_rd(16'hA010, 1'b1);
        @(negedge Clk); Req = 1'b0;
        check("rd1_n1_valid", Rd_Valid, 0);
        check("rd1_n1_ready", Ready, 0);
        check("rd1_n1_mem_en", Mem_En, 0);
        check("rd1_n1_addr", Mem_Addr, 8'h10);
        @(negedge Clk);
        check("rd1_n2_valid", Rd_Valid, 1);
        check("rd1_n2_last", Rd_Last, 1);
        check("rd1_n2_ready", Ready, 1);
        check("rd1_n2_mem_en", Mem_En, 1);

        // Burst with address wrap
        start_req(1'b0, 8'hFE, 16'h0, 4'd3);
        push_rd(16'hA0FE, 1'b0); push_rd(16'hA0FF, 1'b0);
        push_rd(16'hA000, 1'b0); push_rd(16'hA001, 1'b1);
        @(negedge Clk); Req = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            check("wrap_gapless_valid", Rd_Valid, 1);
        end
        repeat (2) @(negedge Clk);
        check("rd_data_hold", Rd_Data, 16'hA001);

        // Write 0x1234 to 0x20, then read it back
        start_req(1'b1, 8'h20, 16'h1234, 4'd7);
        push_wr();
        @(negedge Clk); Req = 1'b0;
        check("wr_n1_en_we", {Mem_En, Mem_Write_EN}, 2'b00);
        check("wr_n1_din", Mem_DIn, 16'h1234);
        @(negedge Clk);
        check("wr_n2_done", Wr_Done, 1);
        check("wr_n2_en_we", {Mem_En, Mem_Write_EN}, 2'b11);
        check("wr_n2_ready", Ready, 1);
        start_req(1'b0, 8'h20, 16'h0, 4'd0);
        push_rd(16'h1234, 1'b1);
        @(negedge Clk); Req = 1'b0;

        // Req held through a 4-word burst: re-accepted right after Rd_Last
        start_req(1'b0, 8'h30, 16'h0, 4'd3);
        for (int i = 0; i < 2; i++) begin
            push_rd(16'hA030, 1'b0); push_rd(16'hA031, 1'b0);
            push_rd(16'hA032, 1'b0); push_rd(16'hA033, 1'b1);
        end
        repeat (4) begin
            @(negedge Clk);
            check("busy_ready_low", Ready, 0);
        end
        @(negedge Clk);
        check("busy_n5_last", Rd_Last, 1);
        check("busy_n5_ready", Ready, 1);
        @(negedge Clk); Req = 1'b0;
        check("busy_n6_reaccept", Ready, 0);
        check("busy_n6_gap", Rd_Valid, 0);
        @(negedge Clk);
        check("busy_n7_valid", Rd_Valid, 1);

        // Reset after the 2nd word of a 16-word burst
        start_req(1'b0, 8'h40, 16'h0, 4'hF);
        push_rd(16'hA040, 1'b0); push_rd(16'hA041, 1'b0);
        @(negedge Clk); Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("rstmid_2nd_valid", Rd_Valid, 1);
        Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        check("rstmid_mem_en", Mem_En, 1);
        check("rstmid_ready", Ready, 1);
        check("rstmid_no_valid", Rd_Valid, 0);
        repeat (3) @(negedge Clk);

        // Back-to-back writes with Req held, then read them back
        start_req(1'b1, 8'h50, 16'h5550, 4'd0);
        for (int i = 0; i < 3; i++) begin
            push_wr();
            @(negedge Clk);
            check("b2b_we_low", {Mem_En, Mem_Write_EN}, 2'b00);
            @(negedge Clk);
            check("b2b_done", Wr_Done, 1);
            Req_Addr = 8'h51 + 8'(i);
            Req_Data = 16'h5551 + 16'(i);
            if (i == 2) Req = 1'b0;
        end
        start_req(1'b0, 8'h50, 16'h0, 4'd2);
        push_rd(16'h5550, 1'b0); push_rd(16'h5551, 1'b0); push_rd(16'h5552, 1'b1);
        @(negedge Clk); Req = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("sb_drained", sb.size(), 0);
        repeat (2) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
